// File: rtl/da_filter_pkg.sv
// Shared types and helpers for the distributed-arithmetic FIR back end.
// The helpers here are used by the shift accumulator and its output scaler.
package da_filter_pkg;

  // Accumulator sequencing state.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } da_state_e;

  // Accumulator width: one full ROM word plus one bit of growth per slice.
  function automatic int acc_width(input int word_w, input int in_w);
    return word_w + in_w;
  endfunction

  // Round half up at bit frac_shift, shift down, then clamp to a signed
  // out_width range. Works on a 64-bit signed value so callers can
  // sign-extend any accumulator width into it.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] value,
                                                   input int frac_shift,
                                                   input int out_width);
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v = value;
    if (frac_shift > 0) begin
      v = v + (64'sd1 <<< (frac_shift - 1));
    end else begin
      v = value;
    end
    v  = v >>> frac_shift;
    hi = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_width - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/da_shift_accumulator_da_output_scaler.sv
// Output scaler for the DA shift accumulator: turns the completed
// accumulator value into the output sample and its valid pulse.
// Build option DA_ACC_ROUND_SAT_EN: round half up and saturate, with one
// extra register stage; otherwise truncate and wrap with a single stage.
module da_output_scaler
  import da_filter_pkg::*;
#(
  parameter int ACC_W      = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_SHIFT = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_valid,
  input  logic signed [ACC_W-1:0]     i_acc,
  output logic signed [OUT_WIDTH-1:0] o_y,
  output logic                        o_valid
);

  logic signed [OUT_WIDTH-1:0] r_y;
  logic                        r_valid;

`ifdef DA_ACC_ROUND_SAT_EN
  logic signed [ACC_W-1:0] r_acc_p;
  logic                    r_valid_p;

  // Capture the completed sum so rounding/saturation gets its own cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_p   <= '0;
      r_valid_p <= 1'b0;
    end else begin
      r_valid_p <= i_valid;
      if (i_valid) begin
        r_acc_p <= i_acc;
      end
    end
  end

  // Round, saturate and publish; y holds between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid_p;
      if (r_valid_p) begin
        r_y <= OUT_WIDTH'(sat_round(64'(r_acc_p), FRAC_SHIFT, OUT_WIDTH));
      end
    end
  end
`else
  // Truncate (wrapping) the completed sum and publish; y holds between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_y <= OUT_WIDTH'(i_acc >>> FRAC_SHIFT);
      end
    end
  end
`endif

  assign o_y     = r_y;
  assign o_valid = r_valid;

endmodule

// File: rtl/da_shift_accumulator.sv
// DA shift accumulator: consumes one registered ROM word per input bit-slice
// (LSB first), applies fold/sign-slice negation and shift-accumulates into
// one output sample per slice sequence.
// Build option DA_ACC_ROUND_SAT_EN selects the rounding/saturating scaler.
module da_shift_accumulator
  import da_filter_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_SHIFT = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        slice_valid,
  input  logic                        slice_first,
  input  logic                        addr_msb,
  input  logic [WORD_WIDTH-1:0]       rom_q,
  output logic signed [OUT_WIDTH-1:0] y,
  output logic                        y_valid,
  output logic                        busy
);

  localparam int ACC_W = acc_width(WORD_WIDTH, IN_WIDTH);
  localparam int CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IN_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (FRAC_SHIFT + OUT_WIDTH > ACC_W) begin : g_bad_cfg
    $error("da_shift_accumulator: FRAC_SHIFT + OUT_WIDTH exceeds accumulator width");
  end

  // Control delayed by one cycle so it lines up with the ROM output.
  logic r_valid_d;
  logic r_first_d;
  logic r_msb_d;

  da_state_e              r_state;
  da_state_e              w_state_next;
  logic [CNT_W-1:0]       r_count;
  logic [CNT_W-1:0]       w_count_next;
  logic signed [ACC_W-1:0] r_acc;

  logic [CNT_W-1:0]        w_idx;
  logic                    w_sign_slice;
  logic                    w_neg;
  logic signed [ACC_W-1:0] w_q_ext;
  logic signed [ACC_W-1:0] w_term;
  logic signed [ACC_W-1:0] w_base;
  logic signed [ACC_W-1:0] w_acc_next;
  logic                    w_accept;
  logic                    w_done;

  // Register the control presented alongside the ROM address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_d <= 1'b0;
      r_first_d <= 1'b0;
      r_msb_d   <= 1'b0;
    end else begin
      r_valid_d <= slice_valid;
      r_first_d <= slice_first;
      r_msb_d   <= addr_msb;
    end
  end

  // A first slice is always slice 0, even when it aborts a partial sum.
  assign w_idx        = r_first_d ? {CNT_W{1'b0}} : r_count;
  assign w_sign_slice = (w_idx == LAST_IDX);
  assign w_neg        = r_msb_d ^ w_sign_slice;
  assign w_q_ext      = {{IN_WIDTH{rom_q[WORD_WIDTH-1]}}, rom_q};
  assign w_term       = w_neg ? -w_q_ext : w_q_ext;
  assign w_base       = r_first_d ? {ACC_W{1'b0}} : r_acc;
  assign w_acc_next   = (w_base >>> 1) + (w_term <<< (IN_WIDTH - 1));
  assign w_accept     = r_valid_d && (r_first_d || (r_state == ACCUM));
  assign w_done       = w_accept && w_sign_slice;

  // Next-state and slice-count decode for each consumed slice.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    case (r_state)
      IDLE: begin
        if (r_valid_d && r_first_d) begin
          if (w_done) begin
            w_state_next = IDLE;
            w_count_next = {CNT_W{1'b0}};
          end else begin
            w_state_next = ACCUM;
            w_count_next = CNT_ONE;
          end
        end else begin
          w_state_next = IDLE;
          w_count_next = r_count;
        end
      end
      ACCUM: begin
        if (r_valid_d) begin
          if (w_done) begin
            w_state_next = IDLE;
            w_count_next = {CNT_W{1'b0}};
          end else begin
            w_state_next = ACCUM;
            w_count_next = w_idx + CNT_ONE;
          end
        end else begin
          w_state_next = ACCUM;
          w_count_next = r_count;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_count_next = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, slice count and accumulator registers; gaps hold everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= {CNT_W{1'b0}};
      r_acc   <= {ACC_W{1'b0}};
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (w_accept) begin
        r_acc <= w_acc_next;
      end
    end
  end

  assign busy = (r_state == ACCUM) || (r_valid_d && r_first_d);

  da_output_scaler #(
    .ACC_W      (ACC_W),
    .OUT_WIDTH  (OUT_WIDTH),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) u_scaler (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_done),
    .i_acc   (w_acc_next),
    .o_y     (y),
    .o_valid (y_valid)
  );

endmodule

// File: tb/tb_da_shift_accumulator.sv
// Directed self-checking bench for da_shift_accumulator with IN_WIDTH=4.
// Inputs change and outputs are sampled on the falling clock edge; the
// bench models the ROM's one-cycle read latency itself.
module tb_da_shift_accumulator;

`ifdef DA_ACC_ROUND_SAT_EN
  localparam int OW = 4;
  localparam int FS = 1;
`else
  localparam int OW = 20;
  localparam int FS = 0;
`endif

  logic                 clk;
  logic                 rst;
  logic                 slice_valid;
  logic                 slice_first;
  logic                 addr_msb;
  logic [15:0]          rom_q;
  logic signed [OW-1:0] y;
  logic                 y_valid;
  logic                 busy;

  logic [15:0] q_pipe;
  int          n_tests;
  int          n_fail;
  int          n_pulse;
  int          p0;

  da_shift_accumulator #(
    .WORD_WIDTH (16),
    .IN_WIDTH   (4),
    .OUT_WIDTH  (OW),
    .FRAC_SHIFT (FS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .slice_valid (slice_valid),
    .slice_first (slice_first),
    .addr_msb    (addr_msb),
    .rom_q       (rom_q),
    .y           (y),
    .y_valid     (y_valid),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: present an address (or idle), feed last cycle's ROM word.
  task automatic cyc(input logic v, input logic f, input logic m, input logic [15:0] q);
    slice_valid = v;
    slice_first = f;
    addr_msb    = m;
    rom_q       = q_pipe;
    q_pipe      = q;
    @(negedge clk);
    if (y_valid === 1'b1) n_pulse++;
  endtask

  task automatic seq4(input logic [15:0] q0, input logic [15:0] q1,
                      input logic [15:0] q2, input logic [15:0] q3,
                      input logic [3:0] m);
    cyc(1'b1, 1'b1, m[0], q0);
    cyc(1'b1, 1'b0, m[1], q1);
    cyc(1'b1, 1'b0, m[2], q2);
    cyc(1'b1, 1'b0, m[3], q3);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; n_pulse = 0; q_pipe = 16'd0;
    rst = 1'b1; slice_valid = 1'b0; slice_first = 1'b0; addr_msb = 1'b0; rom_q = 16'd0;
    @(negedge clk);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    rst = 1'b0;
    chk("reset_y", 32'(y), 32'sd0);
    chk("reset_y_valid", 32'(y_valid), 32'sd0);
    chk("reset_busy", 32'(busy), 32'sd0);
    n_pulse = 0;

`ifdef DA_ACC_ROUND_SAT_EN
    // 0x7FFF, sign slice un-negated: 15*32767 rounds to 245753 -> clamp 7.
    seq4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 4'b1000);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    chk("lat3_no_pulse_at_2", 32'(y_valid), 32'sd0);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    chk("lat3_pulse", 32'(y_valid), 32'sd1);
    chk("sat_high", 32'(y), 32'sd7);
    // Same with slices 0-2 inverted: -15*32767 -> clamp -8.
    seq4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 4'b0111);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    chk("sat_low_inv", 32'(y), -32'sd8);
    // All straight: -32767 -> -16383 -> clamp -8.
    seq4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 4'b0000);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    chk("sat_low", 32'(y), -32'sd8);
    // q=3 constant: sum -3, (-3+1)>>>1 = -1 (truncation would give -2).
    seq4(16'd3, 16'd3, 16'd3, 16'd3, 4'b0000);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    chk("round_half_up", 32'(y), -32'sd1);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    chk("y_hold", 32'(y), -32'sd1);
    chk("pulse_count", 32'(n_pulse), 32'sd4);
`else
    // Constant 5: 5+10+20-40 = -5.
    cyc(1'b1, 1'b1, 1'b0, 16'd5);
    chk("busy_after_first", 32'(busy), 32'sd1);
    cyc(1'b1, 1'b0, 1'b0, 16'd5);
    cyc(1'b1, 1'b0, 1'b0, 16'd5);
    cyc(1'b1, 1'b0, 1'b0, 16'd5);
    chk("const_no_early_pulse", 32'(y_valid), 32'sd0);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    chk("const_pulse", 32'(y_valid), 32'sd1);
    chk("const_y", 32'(y), -32'sd5);
    chk("const_busy_done", 32'(busy), 32'sd0);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    chk("const_pulse_one_cycle", 32'(y_valid), 32'sd0);
    chk("const_y_hold", 32'(y), -32'sd5);

    // Mixed sign: 1-4+12-32 = -23.
    seq4(16'd1, 16'd2, 16'd3, 16'd4, 4'b0010);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    chk("mixed_y", 32'(y), -32'sd23);
    chk("mixed_pulse", 32'(y_valid), 32'sd1);

    // Gaps, then back-to-back constant sequence.
    p0 = n_pulse;
    cyc(1'b1, 1'b1, 1'b0, 16'd1);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    cyc(1'b1, 1'b0, 1'b1, 16'd2);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    chk("gap_busy", 32'(busy), 32'sd1);
    cyc(1'b1, 1'b0, 1'b0, 16'd3);
    cyc(1'b1, 1'b0, 1'b0, 16'd4);
    cyc(1'b1, 1'b1, 1'b0, 16'd5);
    chk("gap_y", 32'(y), -32'sd23);
    chk("b2b_busy_new_seq", 32'(busy), 32'sd1);
    cyc(1'b1, 1'b0, 1'b0, 16'd5);
    cyc(1'b1, 1'b0, 1'b0, 16'd5);
    cyc(1'b1, 1'b0, 1'b0, 16'd5);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    chk("b2b_y", 32'(y), -32'sd5);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    chk("b2b_pulses", 32'(n_pulse - p0), 32'sd2);

    // Abort: two slices of 9, restart with four slices of 5 -> only -5.
    p0 = n_pulse;
    cyc(1'b1, 1'b1, 1'b0, 16'd9);
    cyc(1'b1, 1'b0, 1'b0, 16'd9);
    seq4(16'd5, 16'd5, 16'd5, 16'd5, 4'b0000);
    chk("abort_no_early", 32'(n_pulse - p0), 32'sd0);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    chk("abort_y", 32'(y), -32'sd5);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    chk("abort_pulses", 32'(n_pulse - p0), 32'sd1);

    // Reset during slice 2; remaining non-first slices are ignored.
    p0 = n_pulse;
    cyc(1'b1, 1'b1, 1'b0, 16'd7);
    cyc(1'b1, 1'b0, 1'b0, 16'd7);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 16'd7);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 16'd7);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    cyc(1'b0, 1'b0, 1'b0, 16'd0);
    chk("rst_mid_y", 32'(y), 32'sd0);
    chk("rst_mid_busy", 32'(busy), 32'sd0);
    chk("rst_mid_pulses", 32'(n_pulse - p0), 32'sd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/da_shift_accumulator.md
Name: da_shift_accumulator

Overview:
- Downstream stage of the distributed-arithmetic FIR filter coefficient ROM.
- Consumes the registered ROM word Q, one per input bit-slice, LSB slice first.
- Applies the sign correction implied by the folded (half-size, MSB-XOR) ROM addressing and the two's-complement sign slice.
- Shift-accumulates over IN_WIDTH slices and emits one filter output sample per completed slice sequence.

Parameters:
- WORD_WIDTH, 16, width of ROM word Q (signed).
- IN_WIDTH, 16, input sample width = number of bit-slices per output sample.
- OUT_WIDTH, 16, width of output y (signed).
- FRAC_SHIFT, 15, LSB position of the accumulator taken as y bit 0; must satisfy FRAC_SHIFT + OUT_WIDTH <= WORD_WIDTH + IN_WIDTH.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- slice_valid  in  1  a ROM address is presented to the ROM in this cycle
- slice_first  in  1  qualifies slice_valid: this is slice 0 (LSB) of a new sample
- addr_msb  in  1  MSB of the ROM address presented this cycle (the fold/invert bit)
- rom_q  in  WORD_WIDTH  ROM output; valid one cycle after its address
- y  out  OUT_WIDTH  filter output sample, signed
- y_valid  out  1  one-cycle pulse: y updated
- busy  out  1  a slice sequence is in progress

Behaviour:
- Reset (rst=1 at a clk edge): acc=0, slice count=0, state IDLE, delayed control cleared, y=0, y_valid=0, busy=0. Reset mid-sequence discards the partial sum; no y_valid is produced for it.
- Control alignment: slice_valid, slice_first and addr_msb are registered at edge E0, when the ROM latches the address. At E1, rom_q and the registered control are consumed together.
- Term: neg = addr_msb_d XOR sign_slice, where sign_slice = (count == IN_WIDTH-1). term = neg ? -sext(rom_q) : sext(rom_q).
- Accumulator: ACC_W = WORD_WIDTH + IN_WIDTH, signed. Per consumed slice: acc_next = (base >>> 1) + (term <<< (IN_WIDTH-1)). base = 0 on a first slice, otherwise acc. After IN_WIDTH slices acc = sum over b of term_b * 2^b, which is exact.
- States:
  - IDLE: a consumed slice with first=1 loads acc_next, sets count=1 and goes to ACCUM. A consumed slice with first=0 is ignored.
  - ACCUM: each consumed slice increments count.
    - On the slice with count == IN_WIDTH-1: y <= scale(acc_next), y_valid=1 for one cycle, state goes to IDLE.
    - A consumed slice with first=1 in ACCUM aborts the partial sum and restarts at count=1; no output is produced for the aborted sample.
- Gaps: cycles with slice_valid=0 hold acc and count, so slices may be non-contiguous.
- Latency: y/y_valid are visible after E1 of the last slice, i.e. 2 clk edges after the last address is presented.
- Back-to-back: a first slice may be presented in the cycle immediately after a last slice. Full throughput is one sample per IN_WIDTH cycles.
- busy = (state == ACCUM) or a registered first slice is pending. busy is 0 in the cycle y_valid is 1 unless a new sequence has started.
- scale (default): y = acc_next[FRAC_SHIFT +: OUT_WIDTH], a truncation that wraps on overflow.
- y holds its value between pulses.
- IN_WIDTH = 1: every first slice is also the sign slice and completes immediately.

Optional Feature:
- Macro: DA_ACC_ROUND_SAT_EN.
- Defined:
  - scale adds 2^(FRAC_SHIFT-1) when FRAC_SHIFT > 0 (round half up), then shifts.
  - Saturates to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Adds one pipeline register, so latency becomes 3 edges; y_valid is delayed to match.
- Undefined: truncate and wrap, with 2-edge latency.

Decomposition:
- Package da_filter_pkg:
  - state enum (IDLE, ACCUM);
  - function computing ACC_W;
  - function sat_round(value, frac_shift, out_width) for use by sibling blocks.
- One sub-module, da_output_scaler: truncation or rounding/saturation plus the optional register stage. It isolates the macro-dependent logic.

Test Plan:
- Common setting: IN_WIDTH=4, WORD_WIDTH=16, FRAC_SHIFT=0, OUT_WIDTH=20.
- Constant: rom_q=5 for all 4 slices, addr_msb=0 -> y=-5 (5+10+20-40), y_valid one pulse 2 edges after slice 3.
- Mixed sign: rom_q=1,2,3,4 and addr_msb=0,1,0,0 -> y=-23 (1-4+12-32).
- Gaps and back-to-back: same as the mixed-sign case with idle cycles between slices, then an immediate second sequence with rom_q=5 constant -> y=-23 then y=-5, exactly two y_valid pulses.
- Abort: 2 slices, then a new slice_first, then 4 clean slices (rom_q=5) -> single y=-5; no output for the aborted sequence. Reset asserted during slice 2 -> no y_valid, and y=0.
- With DA_ACC_ROUND_SAT_EN, OUT_WIDTH=4, FRAC_SHIFT=1:
  - rom_q=0x7FFF all slices -> y=7 (saturated high);
  - rom_q=0x7FFF with addr_msb=1 on slices 0-2 -> y=-8 (saturated low);
  - latency is 3 edges.
